// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe move controller: FSM states, winner codes
// and the eight winning line masks.
package ttt_pkg;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    WRITE = 2'd1,
    CHECK = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam int NUM_LINES = 8;

  // Index 0..2 rows, 3..5 columns, 6..7 diagonals; bit n is cell n.
  localparam logic [NUM_LINES-1:0][8:0] WIN_LINES = {
    9'h054, 9'h111, 9'h124, 9'h092, 9'h049, 9'h1C0, 9'h038, 9'h007
  };

  localparam logic [8:0] BOARD_FULL = 9'h1FF;

  function automatic logic line_full(input logic [8:0] mask, input logic [8:0] line);
    return ((mask & line) == line);
  endfunction

endpackage

// File: rtl/ttt_win_check.sv
// Combinational win detector: flags when a player's occupancy mask covers any
// complete row, column or diagonal.
module ttt_win_check
  import ttt_pkg::*;
(
  input  logic [8:0] mask,
  output logic       win
);

  // OR-reduce the eight line hits
  always_comb begin
    win = 1'b0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (line_full(mask, WIN_LINES[i])) begin
        win = 1'b1;
      end else begin
        win = win;
      end
    end
  end

endmodule

// File: rtl/ttt_move_controller.sv
// Turn sequencer and requester arbiter: grants the player on turn, drives the
// position decoder once per accepted move, tracks both boards and decides the game.
module ttt_move_controller
  import ttt_pkg::*;
#(
  parameter int CELLS        = 9,
  parameter bit FIRST_PLAYER = 1'b0,
  parameter int MOVE_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic       p0_req,
  input  logic [3:0] p0_pos,
  input  logic       p1_req,
  input  logic [3:0] p1_pos,
  output logic [3:0] dec_pos,
  output logic       dec_en,
  output logic       cur_player,
  output logic       move_ack,
  output logic       illegal,
  output logic       timeout,
  output logic [8:0] board_x,
  output logic [8:0] board_o,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int CW = (MOVE_TIMEOUT > 0) ? $clog2(MOVE_TIMEOUT + 1) : 1;
  localparam int TO_LAST = (MOVE_TIMEOUT > 0) ? (MOVE_TIMEOUT - 1) : 0;
  localparam logic [CW-1:0] TO_LAST_C = CW'(TO_LAST);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [4:0]    CELLS_C   = 5'(CELLS);

  state_t        state_r;
  logic [3:0]    dec_pos_r;
  logic          dec_en_r;
  logic          cur_player_r;
  logic          move_ack_r;
  logic          illegal_r;
  logic          timeout_r;
  logic [8:0]    board_x_r;
  logic [8:0]    board_o_r;
  logic          game_over_r;
  logic [1:0]    winner_r;
  logic [CW-1:0] cnt_r;

  logic          sel_req_s;
  logic [3:0]    sel_pos_s;
  logic [15:0]   occ_ext_s;
  logic          legal_s;
  logic          expire_s;
  logic          win_x_s;
  logic          win_o_s;
  logic          cur_win_s;
  logic          full_s;
  logic [8:0]    onehot_s;

  ttt_win_check u_win_x (
    .mask (board_x_r),
    .win  (win_x_s)
  );

  ttt_win_check u_win_o (
    .mask (board_o_r),
    .win  (win_o_s)
  );

  // Request selection, legality, timeout expiry and board evaluation
  always_comb begin
    sel_req_s = 1'b0;
    sel_pos_s = 4'd0;
    legal_s   = 1'b0;
    expire_s  = 1'b0;
    cur_win_s = 1'b0;
    occ_ext_s = {7'd0, (board_x_r | board_o_r)};
    full_s    = ((board_x_r | board_o_r) == BOARD_FULL);
    onehot_s  = 9'd1 << dec_pos_r;

    if (cur_player_r) begin
      sel_req_s = p1_req;
      sel_pos_s = p1_pos;
      cur_win_s = win_o_s;
    end else begin
      sel_req_s = p0_req;
      sel_pos_s = p0_pos;
      cur_win_s = win_x_s;
    end

    // Out-of-range cells are rejected before the occupancy lookup matters
    if (sel_req_s && ({1'b0, sel_pos_s} < CELLS_C) && !occ_ext_s[sel_pos_s]) begin
      legal_s = 1'b1;
    end else begin
      legal_s = 1'b0;
    end

    if ((MOVE_TIMEOUT > 0) && (cnt_r == TO_LAST_C)) begin
      expire_s = 1'b1;
    end else begin
      expire_s = 1'b0;
    end
  end

  // Turn FSM with all outputs registered; new_game behaves as a synchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= WAIT;
      dec_pos_r    <= 4'd0;
      dec_en_r     <= 1'b0;
      cur_player_r <= FIRST_PLAYER;
      move_ack_r   <= 1'b0;
      illegal_r    <= 1'b0;
      timeout_r    <= 1'b0;
      board_x_r    <= 9'd0;
      board_o_r    <= 9'd0;
      game_over_r  <= 1'b0;
      winner_r     <= WIN_NONE;
      cnt_r        <= '0;
    end else if (new_game) begin
      state_r      <= WAIT;
      dec_pos_r    <= 4'd0;
      dec_en_r     <= 1'b0;
      cur_player_r <= FIRST_PLAYER;
      move_ack_r   <= 1'b0;
      illegal_r    <= 1'b0;
      timeout_r    <= 1'b0;
      board_x_r    <= 9'd0;
      board_o_r    <= 9'd0;
      game_over_r  <= 1'b0;
      winner_r     <= WIN_NONE;
      cnt_r        <= '0;
    end else begin
      dec_en_r   <= 1'b0;
      move_ack_r <= 1'b0;
      illegal_r  <= 1'b0;
      timeout_r  <= 1'b0;
      case (state_r)
        WAIT: begin
          if (legal_s) begin
            dec_pos_r  <= sel_pos_s;
            dec_en_r   <= 1'b1;
            move_ack_r <= 1'b1;
            state_r    <= WRITE;
          end else begin
            illegal_r <= sel_req_s;
            // A legal request on the expiry cycle takes the branch above instead
            if (expire_s) begin
              timeout_r    <= 1'b1;
              cur_player_r <= ~cur_player_r;
              cnt_r        <= '0;
            end else if (cnt_r != CNT_MAX) begin
              cnt_r <= cnt_r + CW'(1);
            end else begin
              cnt_r <= cnt_r;
            end
          end
        end
        WRITE: begin
          if (cur_player_r) begin
            board_o_r <= board_o_r | onehot_s;
          end else begin
            board_x_r <= board_x_r | onehot_s;
          end
          state_r <= CHECK;
        end
        CHECK: begin
          if (cur_win_s) begin
            winner_r    <= cur_player_r ? WIN_O : WIN_X;
            game_over_r <= 1'b1;
            state_r     <= OVER;
          end else if (full_s) begin
            winner_r    <= WIN_DRAW;
            game_over_r <= 1'b1;
            state_r     <= OVER;
          end else begin
            cur_player_r <= ~cur_player_r;
            cnt_r        <= '0;
            state_r      <= WAIT;
          end
        end
        OVER: begin
          state_r <= OVER;
        end
        default: begin
          state_r <= WAIT;
        end
      endcase
    end
  end

  assign dec_pos    = dec_pos_r;
  assign dec_en     = dec_en_r;
  assign cur_player = cur_player_r;
  assign move_ack   = move_ack_r;
  assign illegal    = illegal_r;
  assign timeout    = timeout_r;
  assign board_x    = board_x_r;
  assign board_o    = board_o_r;
  assign game_over  = game_over_r;
  assign winner     = winner_r;

endmodule

// File: tb/tb_ttt_move_controller.sv
// Directed bench: per-cycle vector table for arbitration and legality, then
// hand-written games, new_game/reset corners and the turn timeout.
module tb_ttt_move_controller;
  import ttt_pkg::*;

  typedef struct packed {
    logic       en;
    logic [3:0] dpos;
    logic       ack;
    logic       ill;
    logic       to;
    logic       cp;
    logic [8:0] bx;
    logic [8:0] bo;
    logic       go;
    logic [1:0] win;
  } out_t;

  typedef struct packed {
    logic       ng;
    logic       r0;
    logic [3:0] p0;
    logic       r1;
    logic [3:0] p1;
  } in_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk, rst_n;
  logic new_game, p0_req, p1_req;
  logic [3:0] p0_pos, p1_pos;
  logic [3:0] dec_pos;
  logic dec_en, cur_player, move_ack, illegal, timeout, game_over;
  logic [8:0] board_x, board_o;
  logic [1:0] winner;

  logic new_game_1, p0_req_1, p1_req_1;
  logic [3:0] p0_pos_1, p1_pos_1;
  logic [3:0] dec_pos_1;
  logic dec_en_1, cur_player_1, move_ack_1, illegal_1, timeout_1, game_over_1;
  logic [8:0] board_x_1, board_o_1;
  logic [1:0] winner_1;

  int checks = 0;
  int errors = 0;
  logic [8:0] mbx, mbo;
  vec_t vecs [16];

  ttt_move_controller dut (
    .clk(clk), .rst_n(rst_n), .new_game(new_game),
    .p0_req(p0_req), .p0_pos(p0_pos), .p1_req(p1_req), .p1_pos(p1_pos),
    .dec_pos(dec_pos), .dec_en(dec_en), .cur_player(cur_player),
    .move_ack(move_ack), .illegal(illegal), .timeout(timeout),
    .board_x(board_x), .board_o(board_o), .game_over(game_over), .winner(winner)
  );

  ttt_move_controller #(.MOVE_TIMEOUT(5)) dut_to (
    .clk(clk), .rst_n(rst_n), .new_game(new_game_1),
    .p0_req(p0_req_1), .p0_pos(p0_pos_1), .p1_req(p1_req_1), .p1_pos(p1_pos_1),
    .dec_pos(dec_pos_1), .dec_en(dec_en_1), .cur_player(cur_player_1),
    .move_ack(move_ack_1), .illegal(illegal_1), .timeout(timeout_1),
    .board_x(board_x_1), .board_o(board_o_1), .game_over(game_over_1), .winner(winner_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic out_t obs0();
    out_t o;
    o.en = dec_en; o.dpos = dec_pos; o.ack = move_ack; o.ill = illegal;
    o.to = timeout; o.cp = cur_player; o.bx = board_x; o.bo = board_o;
    o.go = game_over; o.win = winner;
    return o;
  endfunction

  function automatic vec_t mk(input logic ng, r0, input logic [3:0] p0, input logic r1,
                              input logic [3:0] p1, input logic en, input logic [3:0] dp,
                              input logic ack, ill, cp, input logic [8:0] bx, bo,
                              input logic go, input logic [1:0] w);
    vec_t v;
    v.i = '{ng: ng, r0: r0, p0: p0, r1: r1, p1: p1};
    v.o = '{en: en, dpos: dp, ack: ack, ill: ill, to: 1'b0, cp: cp,
            bx: bx, bo: bo, go: go, win: w};
    return v;
  endfunction

  task automatic check_out(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full move: request, WRITE response, CHECK board, then turn/outcome
  task automatic play(input logic p, input logic [3:0] pos, input logic [1:0] exp_win);
    out_t o;
    if (p) begin p1_req = 1'b1; p1_pos = pos; end
    else begin p0_req = 1'b1; p0_pos = pos; end
    step(); o = obs0();
    check_val($sformatf("mv%0d_%0d_write", p, pos), {o.en, o.ack, o.ill, o.dpos},
              {1'b1, 1'b1, 1'b0, pos});
    p0_req = 1'b0; p1_req = 1'b0;
    if (p) mbo = mbo | (9'd1 << pos); else mbx = mbx | (9'd1 << pos);
    step(); o = obs0();
    check_val($sformatf("mv%0d_%0d_board", p, pos), {o.en, o.bx, o.bo}, {1'b0, mbx, mbo});
    step(); o = obs0();
    if (exp_win == WIN_NONE)
      check_val($sformatf("mv%0d_%0d_turn", p, pos), {o.go, o.win, o.cp}, {1'b0, WIN_NONE, ~p});
    else
      check_val($sformatf("mv%0d_%0d_end", p, pos), {o.go, o.win, o.cp}, {1'b1, exp_win, p});
  endtask

  initial begin
    //            ng r0 p0    r1 p1     en dpos  ack ill cp bx      bo      go win
    vecs[0]  = mk(0, 0, 4'd0, 0, 4'd0,  0, 4'd0, 0, 0, 0, 9'h000, 9'h000, 0, 2'b00);
    vecs[1]  = mk(0, 1, 4'd4, 0, 4'd0,  1, 4'd4, 1, 0, 0, 9'h000, 9'h000, 0, 2'b00);
    vecs[2]  = mk(0, 0, 4'd0, 0, 4'd0,  0, 4'd4, 0, 0, 0, 9'h010, 9'h000, 0, 2'b00);
    vecs[3]  = mk(0, 0, 4'd0, 0, 4'd0,  0, 4'd4, 0, 0, 1, 9'h010, 9'h000, 0, 2'b00);
    vecs[4]  = mk(0, 0, 4'd0, 1, 4'd4,  0, 4'd4, 0, 1, 1, 9'h010, 9'h000, 0, 2'b00);
    vecs[5]  = mk(0, 0, 4'd0, 1, 4'd9,  0, 4'd4, 0, 1, 1, 9'h010, 9'h000, 0, 2'b00);
    vecs[6]  = mk(0, 0, 4'd0, 1, 4'd9,  0, 4'd4, 0, 1, 1, 9'h010, 9'h000, 0, 2'b00);
    vecs[7]  = mk(0, 1, 4'd0, 0, 4'd0,  0, 4'd4, 0, 0, 1, 9'h010, 9'h000, 0, 2'b00);
    vecs[8]  = mk(0, 0, 4'd0, 1, 4'd0,  1, 4'd0, 1, 0, 1, 9'h010, 9'h000, 0, 2'b00);
    vecs[9]  = mk(0, 0, 4'd0, 0, 4'd0,  0, 4'd0, 0, 0, 1, 9'h010, 9'h001, 0, 2'b00);
    vecs[10] = mk(0, 0, 4'd0, 0, 4'd0,  0, 4'd0, 0, 0, 0, 9'h010, 9'h001, 0, 2'b00);
    vecs[11] = mk(0, 1, 4'd1, 1, 4'd2,  1, 4'd1, 1, 0, 0, 9'h010, 9'h001, 0, 2'b00);
    vecs[12] = mk(0, 0, 4'd0, 0, 4'd0,  0, 4'd1, 0, 0, 0, 9'h012, 9'h001, 0, 2'b00);
    vecs[13] = mk(0, 0, 4'd0, 0, 4'd0,  0, 4'd1, 0, 0, 1, 9'h012, 9'h001, 0, 2'b00);
    vecs[14] = mk(0, 0, 4'd0, 1, 4'd15, 0, 4'd1, 0, 1, 1, 9'h012, 9'h001, 0, 2'b00);
    vecs[15] = mk(1, 0, 4'd0, 1, 4'd5,  0, 4'd0, 0, 0, 0, 9'h000, 9'h000, 0, 2'b00);

    rst_n = 1'b0;
    new_game = 1'b0; p0_req = 1'b0; p0_pos = 4'd0; p1_req = 1'b0; p1_pos = 4'd0;
    new_game_1 = 1'b0; p0_req_1 = 1'b0; p0_pos_1 = 4'd0; p1_req_1 = 1'b0; p1_pos_1 = 4'd0;
    mbx = 9'd0; mbo = 9'd0;
    #2;
    check_out("reset", obs0(), '0);
    check_val("reset_to", {timeout_1, cur_player_1, game_over_1, dec_en_1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 16; k++) begin
      {new_game, p0_req, p0_pos, p1_req, p1_pos} = vecs[k].i;
      step();
      check_out($sformatf("vec%0d", k), obs0(), vecs[k].o);
    end
    new_game = 1'b0; p0_req = 1'b0; p1_req = 1'b0;

    // X wins on the top row
    mbx = 9'd0; mbo = 9'd0;
    play(1'b0, 4'd0, WIN_NONE);
    play(1'b1, 4'd3, WIN_NONE);
    play(1'b0, 4'd1, WIN_NONE);
    play(1'b1, 4'd4, WIN_NONE);
    play(1'b0, 4'd2, WIN_X);
    p0_req = 1'b1; p0_pos = 4'd5; p1_req = 1'b1; p1_pos = 4'd6;
    for (int k = 0; k < 3; k++) begin
      step();
      check_val($sformatf("over_frozen%0d", k),
                {dec_en, move_ack, illegal, board_x, board_o, game_over, winner},
                {1'b0, 1'b0, 1'b0, 9'h007, 9'h018, 1'b1, WIN_X});
    end
    p0_req = 1'b0; p1_req = 1'b0; new_game = 1'b1;
    step();
    new_game = 1'b0;
    check_out("ng_after_win", obs0(), '0);

    // Full board with no line
    mbx = 9'd0; mbo = 9'd0;
    play(1'b0, 4'd0, WIN_NONE);
    play(1'b1, 4'd1, WIN_NONE);
    play(1'b0, 4'd2, WIN_NONE);
    play(1'b1, 4'd4, WIN_NONE);
    play(1'b0, 4'd3, WIN_NONE);
    play(1'b1, 4'd5, WIN_NONE);
    play(1'b0, 4'd7, WIN_NONE);
    play(1'b1, 4'd6, WIN_NONE);
    play(1'b0, 4'd8, WIN_DRAW);
    check_val("draw_boards", {board_x, board_o}, {9'h18D, 9'h072});
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    check_out("ng_after_draw", obs0(), '0);

    // new_game during WRITE: decoder pulse stays, move discarded
    p0_req = 1'b1; p0_pos = 4'd4;
    step();
    check_val("ngw_write", {dec_en, move_ack, dec_pos}, {1'b1, 1'b1, 4'd4});
    p0_req = 1'b0; new_game = 1'b1;
    step();
    new_game = 1'b0;
    check_out("ngw_cleared", obs0(), '0);
    step();
    check_out("ngw_no_write", obs0(), '0);

    // Asynchronous reset in the middle of a move
    p0_req = 1'b1; p0_pos = 4'd6;
    step();
    check_val("rst_write", {dec_en, move_ack, dec_pos}, {1'b1, 1'b1, 4'd6});
    p0_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_out("rst_async", obs0(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_out("rst_no_write", obs0(), '0);

    // Turn timeout with MOVE_TIMEOUT=5
    new_game_1 = 1'b1;
    step();
    new_game_1 = 1'b0;
    check_val("to_ng", {timeout_1, cur_player_1}, {1'b0, 1'b0});
    for (int k = 0; k < 4; k++) begin
      step();
      check_val($sformatf("to_wait%0d", k), {timeout_1, cur_player_1}, {1'b0, 1'b0});
    end
    step();
    check_val("to_expire", {timeout_1, cur_player_1}, {1'b1, 1'b1});
    for (int k = 0; k < 4; k++) begin
      step();
      check_val($sformatf("to_wait_o%0d", k), {timeout_1, cur_player_1, move_ack_1},
                {1'b0, 1'b1, 1'b0});
    end
    p1_req_1 = 1'b1; p1_pos_1 = 4'd4;
    step();
    p1_req_1 = 1'b0;
    check_val("to_legal_wins", {timeout_1, cur_player_1, move_ack_1, dec_en_1},
              {1'b0, 1'b1, 1'b1, 1'b1});
    step();
    step();
    check_val("to_after_move", {timeout_1, cur_player_1, board_o_1}, {1'b0, 1'b0, 9'h010});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
